// File: rtl/inst_mem_loader_pkg.sv
//------------------------------------------------------------------------------
// Module  : inst_mem_loader_pkg
// Purpose : Shared constants and types for the instruction-memory loader:
//           default widths, the HALT word, and the loader state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package inst_mem_loader_pkg;

  localparam int              PC_BITS          = 11;
  localparam int              INSTRUCTION_BITS = 32;
  localparam int              BYTE_BITS        = 8;
  localparam logic [31:0]     HALT_WORD        = 32'hFFFF_FFFF;

  localparam logic [2:0]      LDR_IDLE         = 3'd0;
  localparam logic [2:0]      LDR_RECV         = 3'd1;
  localparam logic [2:0]      LDR_WRITE        = 3'd2;
  localparam logic [2:0]      LDR_DONE         = 3'd3;
  localparam logic [2:0]      LDR_ERROR        = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = LDR_IDLE,
    ST_RECV  = LDR_RECV,
    ST_WRITE = LDR_WRITE,
    ST_DONE  = LDR_DONE,
    ST_ERROR = LDR_ERROR
  } ldr_state_t;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_mem_loader_if.sv
//------------------------------------------------------------------------------
// Module  : inst_mem_loader_if
// Purpose : Bundles the loader's byte-stream input, its instruction-memory
//           write port and its status flags.
// Ports   : slave  - loader side (receives stream, drives memory/status)
//           master - environment side (drives stream, observes memory/status)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inst_mem_loader_if
  import inst_mem_loader_pkg::*;
#(
  parameter int PC_BITS          = inst_mem_loader_pkg::PC_BITS,
  parameter int INSTRUCTION_BITS = inst_mem_loader_pkg::INSTRUCTION_BITS,
  parameter int BYTE_BITS        = inst_mem_loader_pkg::BYTE_BITS
);

  logic                        i_start;
  logic [BYTE_BITS-1:0]        i_rx_data;
  logic                        i_rx_valid;
  logic                        o_write_inst_mem;
  logic [PC_BITS-1:0]          o_inst_mem_addr;
  logic [INSTRUCTION_BITS-1:0] o_inst_mem_data;
  logic                        o_loading;
  logic                        o_done;
  logic                        o_error;

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
           o_loading, o_done, o_error
  );

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
           o_loading, o_done, o_error
  );

endinterface

`default_nettype wire

// File: rtl/inst_mem_loader_word_assembler.sv
//------------------------------------------------------------------------------
// Module  : inst_mem_loader_word_assembler
// Purpose : Shifts received bytes MSB-first into an instruction word and
//           flags the cycle on which the final byte of a word is accepted.
// Ports   : clk, rst    - clock, async active-high reset
//           clear       - drop any partial word (start of a new load)
//           accept      - take rx_data this cycle
//           rx_data     - incoming byte
//           word_ready  - the byte taken this cycle completes a word
//           word        - shift contents with rx_data appended (complete
//                         word when word_ready is high)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_mem_loader_word_assembler
  import inst_mem_loader_pkg::*;
#(
  parameter int INSTRUCTION_BITS = inst_mem_loader_pkg::INSTRUCTION_BITS,
  parameter int BYTE_BITS        = inst_mem_loader_pkg::BYTE_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        accept,
  input  logic [BYTE_BITS-1:0]        rx_data,
  output logic                        word_ready,
  output logic [INSTRUCTION_BITS-1:0] word
);

  localparam int                  BYTES_PER_WORD = INSTRUCTION_BITS / BYTE_BITS;
  localparam int                  COUNT_BITS     = cnt_bits(BYTES_PER_WORD);
  localparam logic [COUNT_BITS-1:0] LAST_BYTE    = COUNT_BITS'(BYTES_PER_WORD - 1);

  logic [INSTRUCTION_BITS-1:0] shift;
  logic [COUNT_BITS-1:0]       count;

  // Combinational look-ahead so the loader can capture the finished word on
  // the same edge that accepts its last byte.
  generate
    if (BYTES_PER_WORD > 1) begin : g_multi_byte
      assign word = {shift[INSTRUCTION_BITS-BYTE_BITS-1:0], rx_data};
    end else begin : g_single_byte
      assign word = INSTRUCTION_BITS'(rx_data);
    end
  endgenerate

  assign word_ready = accept && (count == LAST_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      count <= '0;
    end else if (clear) begin
      shift <= '0;
      count <= '0;
    end else if (accept) begin
      shift <= word;
      count <= word_ready ? '0 : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_mem_loader.sv
//------------------------------------------------------------------------------
// Module  : inst_mem_loader
// Purpose : Programs instruction memory from a UART byte stream. Bytes are
//           assembled MSB-first into words, each word is written at the next
//           address, and the load ends when the HALT word has been written
//           (done) or the last address was written without one (error).
// Ports   : clk  - system clock
//           rst  - asynchronous active-high reset
//           bus  - inst_mem_loader_if.slave: i_start, i_rx_data, i_rx_valid,
//                  o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
//                  o_loading, o_done, o_error
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int PC_BITS          = inst_mem_loader_pkg::PC_BITS,
  parameter int INSTRUCTION_BITS = inst_mem_loader_pkg::INSTRUCTION_BITS,
  parameter int BYTE_BITS        = inst_mem_loader_pkg::BYTE_BITS,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD =
    INSTRUCTION_BITS'(inst_mem_loader_pkg::HALT_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  inst_mem_loader_if.slave  bus
);

  ldr_state_t                  state;
  ldr_state_t                  state_next;
  logic [PC_BITS-1:0]          addr;
  logic [INSTRUCTION_BITS-1:0] data;

  logic                        start_ok;
  logic                        halt_hit;
  logic                        last_addr;
  logic                        write_continue;
  logic                        accept;
  logic                        word_ready;
  logic [INSTRUCTION_BITS-1:0] word;

  // A load can only be (re)started from a resting state.
  assign start_ok = bus.i_start &&
                    (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

  assign halt_hit  = (data == HALT_WORD);
  assign last_addr = &addr;

  // In the WRITE cycle a byte belongs to the next word only if the load
  // continues; after HALT or the final address it is dropped.
  assign write_continue = (state == ST_WRITE) && !halt_hit && !last_addr;
  assign accept         = bus.i_rx_valid && ((state == ST_RECV) || write_continue);

  inst_mem_loader_word_assembler #(
    .INSTRUCTION_BITS (INSTRUCTION_BITS),
    .BYTE_BITS        (BYTE_BITS)
  ) u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .accept     (accept),
    .rx_data    (bus.i_rx_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.i_start) state_next = ST_RECV;
      end
      ST_RECV: begin
        if (word_ready) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (halt_hit)       state_next = ST_DONE;
        else if (last_addr) state_next = ST_ERROR;
        else                state_next = ST_RECV;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address and data hold between writes; consumers qualify with the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      data <= '0;
    end else begin
      if (start_ok)            addr <= '0;
      else if (write_continue) addr <= addr + 1'b1;
      if (word_ready && state == ST_RECV) data <= word;
    end
  end

  assign bus.o_write_inst_mem = (state == ST_WRITE);
  assign bus.o_inst_mem_addr  = addr;
  assign bus.o_inst_mem_data  = data;
  assign bus.o_loading        = (state == ST_RECV) || (state == ST_WRITE);
  assign bus.o_done           = (state == ST_DONE);
  assign bus.o_error          = (state == ST_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
//------------------------------------------------------------------------------
// Module  : tb_inst_mem_loader
// Purpose : Self-checking bench for inst_mem_loader. A default-width instance
//           covers reset, normal loads, gaps and back-to-back bytes; a
//           PC_BITS=3 instance covers memory overflow.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  inst_mem_loader_if #(.PC_BITS(11), .INSTRUCTION_BITS(32), .BYTE_BITS(8)) bus_m ();
  inst_mem_loader_if #(.PC_BITS(3),  .INSTRUCTION_BITS(32), .BYTE_BITS(8)) bus_s ();

  inst_mem_loader #(.PC_BITS(11), .INSTRUCTION_BITS(32), .BYTE_BITS(8)) dut (
    .clk (clk), .rst (rst), .bus (bus_m)
  );

  inst_mem_loader #(.PC_BITS(3), .INSTRUCTION_BITS(32), .BYTE_BITS(8)) dut_small (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic        w;
    logic [10:0] a;
    logic [31:0] dat;
    logic        ld;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic s, input logic v, input logic [7:0] d,
                     input logic w, input logic [10:0] a, input logic [31:0] dat,
                     input logic ld, input logic dn, input logic er);
    vec_t t;
    t.s = s; t.v = v; t.d = d; t.w = w; t.a = a; t.dat = dat;
    t.ld = ld; t.dn = dn; t.er = er;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic force_ad,
                     input logic aw, input logic [10:0] aa, input logic [31:0] ad,
                     input logic al, input logic adn, input logic aer,
                     input logic ew, input logic [10:0] ea, input logic [31:0] ed,
                     input logic el, input logic edn, input logic eer);
    logic ok;
    ok = (aw === ew) && (al === el) && (adn === edn) && (aer === eer);
    if (ew || force_ad) ok = ok && (aa === ea) && (ad === ed);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got w=%b a=%h d=%h ld=%b dn=%b er=%b, want w=%b a=%h d=%h ld=%b dn=%b er=%b",
               nm, aw, aa, ad, al, adn, aer, ew, ea, ed, el, edn, eer);
    end
  endtask

  task automatic chk_m(input string nm, input logic force_ad, input logic ew,
                       input logic [10:0] ea, input logic [31:0] ed,
                       input logic el, input logic edn, input logic eer);
    chk(nm, force_ad, bus_m.o_write_inst_mem, bus_m.o_inst_mem_addr, bus_m.o_inst_mem_data,
        bus_m.o_loading, bus_m.o_done, bus_m.o_error, ew, ea, ed, el, edn, eer);
  endtask

  task automatic chk_s(input string nm, input logic ew, input logic [10:0] ea,
                       input logic [31:0] ed, input logic el, input logic edn, input logic eer);
    chk(nm, 1'b0, bus_s.o_write_inst_mem, {8'b0, bus_s.o_inst_mem_addr}, bus_s.o_inst_mem_data,
        bus_s.o_loading, bus_s.o_done, bus_s.o_error, ew, ea, ed, el, edn, eer);
  endtask

  task automatic drv_m(input logic s, input logic v, input logic [7:0] d);
    bus_m.i_start = s; bus_m.i_rx_valid = v; bus_m.i_rx_data = d;
  endtask

  task automatic step_m(input logic s, input logic v, input logic [7:0] d);
    drv_m(s, v, d);
    @(posedge clk); #1;
  endtask

  task automatic step_s(input logic s, input logic v, input logic [7:0] d);
    bus_s.i_start = s; bus_s.i_rx_valid = v; bus_s.i_rx_data = d;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bb [16];
    logic [31:0] bw [4];
    logic [7:0]  gb [8];
    int          nwr;

    drv_m(1'b0, 1'b0, 8'h00);
    bus_s.i_start = 1'b0; bus_s.i_rx_valid = 1'b0; bus_s.i_rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-load, then a clean load of four fresh bytes.
    chk_m("reset", 1'b1, 0, 11'h0, 32'h0, 0, 0, 0);
    step_m(1, 0, 8'h00);  chk_m("rst_start", 1'b0, 0, 0, 0, 1, 0, 0);
    step_m(0, 1, 8'h9A);
    step_m(0, 1, 8'hBC);  chk_m("rst_mid", 1'b0, 0, 0, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1 chk_m("rst_async", 1'b1, 0, 11'h0, 32'h0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    step_m(1, 0, 8'h00);
    step_m(0, 1, 8'h01); step_m(0, 1, 8'h02); step_m(0, 1, 8'h03);
    step_m(0, 1, 8'h04);
    chk_m("rst_fresh", 1'b0, 1, 11'h0, 32'h0102_0304, 1, 0, 0);
    drv_m(0, 0, 8'h00);
    #1 rst = 1'b1;
    #1 rst = 1'b0;

    // Single word then halt, with ignored inputs mixed in.
    add(0,0,8'h00, 0,0,0,                 0,0,0);
    add(0,1,8'hAB, 0,0,0,                 0,0,0);  // valid in IDLE ignored
    add(1,0,8'h00, 0,0,0,                 1,0,0);
    add(0,1,8'h20, 0,0,0,                 1,0,0);
    add(0,0,8'h00, 0,0,0,                 1,0,0);
    add(0,1,8'h01, 0,0,0,                 1,0,0);
    add(1,1,8'h00, 0,0,0,                 1,0,0);  // start in RECV ignored
    add(0,0,8'h00, 0,0,0,                 1,0,0);
    add(0,1,8'h05, 1,11'd0,32'h2001_0005, 1,0,0);
    add(0,0,8'h00, 0,0,0,                 1,0,0);
    add(0,1,8'hFF, 0,0,0,                 1,0,0);
    add(0,0,8'h00, 0,0,0,                 1,0,0);
    add(0,1,8'hFF, 0,0,0,                 1,0,0);
    add(0,1,8'hFF, 0,0,0,                 1,0,0);
    add(0,1,8'hFF, 1,11'd1,32'hFFFF_FFFF, 1,0,0);
    add(0,0,8'h00, 0,0,0,                 0,1,0);
    add(0,1,8'h77, 0,0,0,                 0,1,0);  // valid in DONE ignored
    add(0,1,8'h77, 0,0,0,                 0,1,0);
    add(1,0,8'h00, 0,0,0,                 1,0,0);  // restart clears done
    foreach (tbl[i]) begin
      step_m(tbl[i].s, tbl[i].v, tbl[i].d);
      chk_m($sformatf("vec%0d", i), 1'b0, tbl[i].w, tbl[i].a, tbl[i].dat,
            tbl[i].ld, tbl[i].dn, tbl[i].er);
    end

    // Back-to-back bytes, including the WRITE cycles.
    bw[0] = 32'h1122_3344; bw[1] = 32'hA5A5_5A5A;
    bw[2] = 32'h0000_0000; bw[3] = 32'hFFFF_FFFF;
    for (int k = 0; k < 16; k++) bb[k] = bw[k/4][31-8*(k%4) -: 8];
    for (int k = 0; k < 16; k++) begin
      step_m(0, 1, bb[k]);
      if (k % 4 == 3) chk_m("b2b_wr", 1'b0, 1, 11'(k/4), bw[k/4], 1, 0, 0);
      else            chk_m("b2b_nowr", 1'b0, 0, 0, 0, 1, 0, 0);
    end
    step_m(0, 1, 8'hAA);  chk_m("b2b_done", 1'b0, 0, 0, 0, 0, 1, 0);

    // Gapped bytes: 0..7 idle cycles before each strobe.
    step_m(1, 0, 8'h00);  chk_m("gap_start", 1'b0, 0, 0, 0, 1, 0, 0);
    gb[0] = 8'h20; gb[1] = 8'h01; gb[2] = 8'h00; gb[3] = 8'h05;
    gb[4] = 8'hFF; gb[5] = 8'hFF; gb[6] = 8'hFF; gb[7] = 8'hFF;
    nwr = 0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < (k * 3) % 8; g++) begin
        step_m(0, 0, 8'h00);
        if (bus_m.o_write_inst_mem) nwr++;
        chk_m("gap_idle", 1'b0, 0, 0, 0, 1, 0, 0);
      end
      step_m(0, 1, gb[k]);
      if (bus_m.o_write_inst_mem) nwr++;
      if (k == 3)      chk_m("gap_wr0", 1'b0, 1, 11'd0, 32'h2001_0005, 1, 0, 0);
      else if (k == 7) chk_m("gap_wr1", 1'b0, 1, 11'd1, 32'hFFFF_FFFF, 1, 0, 0);
      else             chk_m("gap_byte", 1'b0, 0, 0, 0, 1, 0, 0);
    end
    step_m(0, 0, 8'h00);  chk_m("gap_done", 1'b0, 0, 0, 0, 0, 1, 0);
    n_vec++;
    if (nwr != 2) begin
      n_err++;
      $display("FAIL gap_count: got %0d write pulses, want 2", nwr);
    end

    // Overflow on the 8-word instance.
    step_s(1, 0, 8'h00);  chk_s("ovf_start", 0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 8; n++) begin
      logic [31:0] wv;
      wv = {8'(n), 8'h00, 8'h00, 8'(8'hC0 + n)};
      for (int j = 0; j < 4; j++) begin
        step_s(0, 1, wv[31-8*j -: 8]);
        if (j == 3) chk_s("ovf_wr", 1, 11'(n), wv, 1, 0, 0);
      end
    end
    step_s(0, 1, 8'h01);  chk_s("ovf_error", 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 3; j++) begin
      step_s(0, 1, 8'h02);
      chk_s("ovf_nowr", 0, 0, 0, 0, 0, 1);
    end
    step_s(0, 0, 8'h00);  chk_s("ovf_hold", 0, 0, 0, 0, 0, 1);
    step_s(1, 0, 8'h00);  chk_s("ovf_clear", 0, 0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction-memory programming port.
- Receives a byte stream from the debug UART receiver and assembles 32-bit instruction words.
- Drives the write-enable, address and data inputs of the instruction memory inside the fetch stage, one word per write.
- Holds the pipeline stalled while loading, and reports completion once the HALT word has been written.

Parameters:
- PC_BITS, 11, instruction memory address width (word addressed).
- INSTRUCTION_BITS, 32, instruction word width; must be a multiple of BYTE_BITS.
- BYTE_BITS, 8, width of each received byte.
- HALT_WORD, 32'hFFFFFFFF, instruction value that terminates a load.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a load at address 0.
- i_rx_data  in  BYTE_BITS  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_write_inst_mem  out  1  instruction memory write enable; one-cycle pulse per word.
- o_inst_mem_addr  out  PC_BITS  word address for the write.
- o_inst_mem_data  out  INSTRUCTION_BITS  word to write.
- o_loading  out  1  high from acceptance of i_start until DONE or ERROR; the debug unit uses it to hold the pipeline enable low.
- o_done  out  1  level; HALT word written successfully.
- o_error  out  1  level; memory filled without a HALT word.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, byte count=0, word register=0, address=0. All outputs 0.
- States:
  - IDLE: i_start -> RECV; address=0, byte count=0, o_loading=1. i_rx_valid is ignored in IDLE.
  - RECV: each i_rx_valid shifts the byte into the word register, most-significant byte first: word <= {word[INSTRUCTION_BITS-BYTE_BITS-1:0], i_rx_data}. Byte count increments.
    - When the final byte (count = INSTRUCTION_BITS/BYTE_BITS - 1) is accepted: register the full word, clear the count, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - o_write_inst_mem=1; o_inst_mem_addr and o_inst_mem_data hold the word's address and value.
    - Next state:
      - word == HALT_WORD -> DONE.
      - else address == 2^PC_BITS-1 -> ERROR.
      - else address+1, back to RECV.
    - An i_rx_valid arriving in the WRITE cycle is captured as byte 0 of the next word and is not lost. It is discarded if the next state is DONE or ERROR.
  - DONE: o_done=1, o_loading=0. i_start -> RECV with address 0, o_done cleared.
  - ERROR: o_error=1, o_loading=0. i_start -> RECV with address 0, o_error cleared.
- Latency: o_write_inst_mem asserts on the cycle after the valid cycle of the last byte of a word.
- Between writes, o_inst_mem_addr and o_inst_mem_data hold their last values. Consumers qualify them only with o_write_inst_mem.
- The HALT word is itself written to memory, so the CPU stops on it.
- i_start while in RECV or WRITE is ignored; a load cannot be restarted mid-stream except by reset.
- Address arithmetic is unsigned PC_BITS wide. The last address is written before the ERROR check, so no wrap-around write ever occurs.
- Reset mid-load discards the partial word. Memory contents already written are unaffected.

Decomposition:
- Shared constants header (existing constants include): PC_BITS, INSTRUCTION_BITS, BYTE_BITS, HALT_WORD, and state encodings LDR_IDLE/RECV/WRITE/DONE/ERROR (3-bit).
- Natural sub-module: word_assembler. It holds the shift register and byte counter, and has the outputs word_ready and word. The loader FSM around it owns the address, write strobe and status flags.

Test Plan:
- Reset/idle: assert rst mid-RECV after 2 bytes -> all outputs 0 immediately; a fresh i_start plus 4 bytes writes address 0 with only the new bytes.
- Single word then halt: i_start; bytes 20,01,00,05, then FF,FF,FF,FF ->
  - write pulse at addr 0 with data 0x20010005, one cycle after byte 05;
  - write at addr 1 with data 0xFFFFFFFF;
  - o_done=1 the next cycle, o_loading=0.
- Gapped bytes: same stream with 0-7 idle cycles between valid strobes -> identical writes; exactly one write pulse per 4 bytes.
- Back-to-back: i_rx_valid every cycle, including in the WRITE cycle, for 3 words plus HALT -> writes to addresses 0..3 with correct data and no dropped bytes.
- Overflow: PC_BITS=3, stream 8 non-halt words -> writes to addresses 0..7, then o_error=1 and no 9th write; i_start clears o_error.
- Ignored inputs: i_rx_valid in IDLE/DONE, and i_start during RECV -> no write pulses and no state change.
